// File: rtl/systolic_skew_feeder.sv
// Feeds one weight column and a diagonally skewed activation stream into a systolic array.
// Row r of every accepted activation vector is delayed r extra cycles relative to row 0.
module systolic_skew_feeder #(
    parameter int ROWS = 4,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         num_vec,
    input  logic [ROWS*DW-1:0] w_data,
    input  logic               in_valid,
    input  logic [ROWS*DW-1:0] in_data,
    output logic               in_ready,
    output logic               load_b,
    output logic [ROWS*DW-1:0] b_out,
    output logic [ROWS*DW-1:0] a_skew,
    output logic               busy,
    output logic               done
);

    localparam int DCW = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic [ROWS*DW-1:0] b_q, b_d;
    logic               xfer;

    // Control outputs are a pure decode of the state register, so reset clears them at once.
    assign in_ready = (state_q == S_STREAM) && (cnt_q != 8'd0);
    assign load_b   = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign xfer     = in_valid & in_ready;
    assign b_out    = b_q;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = num_vec;
                    b_d     = w_data;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q != 8'd0) ? S_STREAM : S_FIN;
            end
            S_STREAM: begin
                if (xfer) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_DRAIN;
                        dcnt_d  = DCW'(ROWS - 2);
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    dcnt_d = dcnt_q - DCW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            dcnt_q  <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            b_q     <= b_d;
        end
    end

    // Row r is a chain of r+1 registers; non-transfer cycles push zeros so the skew flushes clean.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] pipe_q [0:r];
        logic [DW-1:0] pipe_d [0:r];

        always_comb begin
            pipe_d[0] = xfer ? in_data[r*DW +: DW] : '0;
            for (int k = 1; k <= r; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        // NOTE: the skew chains are reset explicitly; they are few small registers, not a RAM.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k <= r; k++) begin
                    pipe_q[k] <= pipe_d[k];
                end
            end
        end

        assign a_skew[r*DW +: DW] = pipe_q[r];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (ROWS=4, DW=16).
// Cycle c is the interval just after the c-th rising edge following the start cycle (c=0).
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 16;
    localparam int W    = ROWS * DW;

    localparam logic [W-1:0] WTS  = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [W-1:0] WTS2 = {16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    localparam logic [W-1:0] JUNK = {4{16'hBEEF}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_vec = 8'd0;
    logic [W-1:0] w_data = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         load_b;
    logic [W-1:0] b_out;
    logic [W-1:0] a_skew;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    systolic_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_vec  (num_vec),
        .w_data   (w_data),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .load_b   (load_b),
        .b_out    (b_out),
        .a_skew   (a_skew),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Activation vector k: row r carries 0x10*k + r.
    function automatic logic [W-1:0] vec(input int k);
        logic [W-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v[r*DW +: DW] = DW'(16 * k + r);
        end
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [7:0] n, input logic [W-1:0] w);
        start   = 1'b1;
        num_vec = n;
        w_data  = w;
        next_cycle();
        start   = 1'b0;
        num_vec = 8'hAA;
        w_data  = JUNK;
    endtask

    task automatic test_reset();
        logic [3:0] ctrl;
        in_valid = 1'b1;
        in_data  = JUNK;
        #12;
        ctrl = {load_b, in_ready, busy, done};
        checks++;
        if (ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", ctrl);
        end
        checks++;
        if (b_out !== '0) begin
            errors++;
            $display("FAIL reset_b_out: got %h want 0", b_out);
        end
        checks++;
        if (a_skew !== '0) begin
            errors++;
            $display("FAIL reset_a_skew: got %h want 0", a_skew);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue_start(8'd0, WTS);
        ctrl = {load_b, in_ready, busy, done};
        checks++;
        if (ctrl !== 4'b1010) begin
            errors++;
            $display("FAIL first_start_load: got %b want 1010", ctrl);
        end
        next_cycle();
        ctrl = {load_b, in_ready, busy, done};
        checks++;
        if (ctrl !== 4'b0011) begin
            errors++;
            $display("FAIL first_start_fin: got %b want 0011", ctrl);
        end
        next_cycle();
    endtask

    task automatic test_zero_vec();
        logic [3:0] ctrl, exp_ctrl;
        in_valid = 1'b1;
        in_data  = JUNK;
        issue_start(8'd0, WTS);
        for (int c = 1; c <= 4; c++) begin
            exp_ctrl = (c == 1) ? 4'b1010 : (c == 2) ? 4'b0011 : 4'b0000;
            ctrl = {load_b, in_ready, busy, done};
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL zero_ctrl c=%0d: got %b want %b", c, ctrl, exp_ctrl);
            end
            checks++;
            if (a_skew !== '0) begin
                errors++;
                $display("FAIL zero_a_skew c=%0d: got %h want 0", c, a_skew);
            end
            checks++;
            if (b_out !== WTS) begin
                errors++;
                $display("FAIL zero_b_out c=%0d: got %h want %h", c, b_out, WTS);
            end
            next_cycle();
        end
    endtask

    // mode 0: continuous valid; mode 1: two bubbles after V0; mode 2: start re-pulsed mid-stream.
    task automatic test_stream(input int mode);
        int tc[3];
        int done_c, xfers, dones;
        logic [3:0] ctrl, exp_ctrl;
        logic [W-1:0] exp_a;
        if (mode == 1) begin
            tc = '{2, 5, 6};
            done_c = 10;
        end else begin
            tc = '{2, 3, 4};
            done_c = 8;
        end
        xfers = 0;
        dones = 0;
        issue_start(8'd3, WTS);
        for (int c = 1; c <= done_c + 2; c++) begin
            in_valid = 1'b1;
            in_data  = JUNK;
            for (int k = 0; k < 3; k++) begin
                if (tc[k] == c) in_data = vec(k);
            end
            if (mode == 1 && (c == 3 || c == 4)) in_valid = 1'b0;
            start   = (mode == 2 && c == 3);
            num_vec = start ? 8'd9 : 8'hAA;
            w_data  = start ? WTS2 : JUNK;
            exp_ctrl = {c == 1, c >= 2 && c <= done_c - 4, c <= done_c, c == done_c};
            ctrl = {load_b, in_ready, busy, done};
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL stream%0d_ctrl c=%0d: got %b want %b", mode, c, ctrl, exp_ctrl);
            end
            checks++;
            if (b_out !== WTS) begin
                errors++;
                $display("FAIL stream%0d_b_out c=%0d: got %h want %h", mode, c, b_out, WTS);
            end
            exp_a = '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < 3; k++) begin
                    if (tc[k] + r + 1 == c) exp_a[r*DW +: DW] = DW'(16 * k + r);
                end
            end
            checks++;
            if (a_skew !== exp_a) begin
                errors++;
                $display("FAIL stream%0d_a_skew c=%0d: got %h want %h", mode, c, a_skew, exp_a);
            end
            if (in_valid && in_ready) xfers++;
            if (done) dones++;
            next_cycle();
        end
        start = 1'b0;
        checks++;
        if (xfers !== 3) begin
            errors++;
            $display("FAIL stream%0d_xfers: got %0d want 3", mode, xfers);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL stream%0d_dones: got %0d want 1", mode, dones);
        end
    endtask

    task automatic test_reset_drain();
        logic [3:0] ctrl;
        in_valid = 1'b1;
        issue_start(8'd3, WTS);
        for (int c = 1; c < 6; c++) begin
            in_data = (c >= 2 && c <= 4) ? vec(c - 2) : JUNK;
            next_cycle();
        end
        checks++;
        if (a_skew[3*DW +: DW] !== 16'h0003 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_pre: got row3=%h busy=%b want 0003/1", a_skew[3*DW +: DW], busy);
        end
        rst_n = 1'b0;
        #1;
        ctrl = {load_b, in_ready, busy, done};
        checks++;
        if (ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL drain_rst_ctrl: got %b want 0000", ctrl);
        end
        checks++;
        if (a_skew !== '0 || b_out !== '0) begin
            errors++;
            $display("FAIL drain_rst_data: got a=%h b=%h want 0/0", a_skew, b_out);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL drain_after c=%0d: got done=%b busy=%b want 0/0", c, done, busy);
            end
            next_cycle();
        end
        test_stream(0);
    endtask

    task automatic test_max();
        int xfers, dones, done_c;
        xfers  = 0;
        dones  = 0;
        done_c = -1;
        in_valid = 1'b1;
        issue_start(8'd255, WTS);
        for (int c = 1; c <= 270; c++) begin
            in_data = (c >= 2 && c <= 256) ? vec(c - 2) : JUNK;
            if (in_valid && in_ready) xfers++;
            if (done) begin
                dones++;
                done_c = c;
            end
            if (c == 257) begin
                checks++;
                if (a_skew[DW-1:0] !== 16'h0FE0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL max_last_row0: got %h rdy=%b want 0fe0/0", a_skew[DW-1:0], in_ready);
                end
            end
            if (c == 260) begin
                checks++;
                if (a_skew[3*DW +: DW] !== 16'h0FE3) begin
                    errors++;
                    $display("FAIL max_last_row3: got %h want 0fe3", a_skew[3*DW +: DW]);
                end
            end
            next_cycle();
        end
        checks++;
        if (done_c !== 260) begin
            errors++;
            $display("FAIL max_done_cycle: got %0d want 260", done_c);
        end
        checks++;
        if (xfers !== 255) begin
            errors++;
            $display("FAIL max_xfers: got %0d want 255", xfers);
        end
        checks++;
        if (dones !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_end: got dones=%0d busy=%b want 1/0", dones, busy);
        end
    endtask

    initial begin
        test_reset();
        test_zero_vec();
        test_stream(0);
        test_stream(1);
        test_stream(2);
        test_reset_drain();
        test_max();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
